// File: rtl/memoredf_config_slave_pkg.sv
// Shared types and constants for the memoredf configuration slave:
// AXI response/burst encodings, FSM states and register index helpers.
package memoredf_cfg_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    localparam logic [63:0] REG_RESET_VALUE  = 64'h0;
    localparam int          ADDR_WINDOW_BITS = 12;

    // One spare bit above the word index so a running burst index can
    // saturate at a value that is always out of range.
    localparam int INDEX_W = ADDR_WINDOW_BITS - 1;
    typedef logic [INDEX_W-1:0] reg_index_t;

    function automatic reg_index_t base_index(input logic [ADDR_WINDOW_BITS-3:0] word_addr);
        return {1'b0, word_addr};
    endfunction

    function automatic reg_index_t step_index(input reg_index_t idx, input axi_burst_e burst);
        return (burst == BURST_INCR && idx != '1) ? idx + 1'b1 : idx;
    endfunction

endpackage

// File: rtl/memoredf_config_slave_if.sv
// AXI4 slave bus bundle for the memoredf configuration slave.
interface memoredf_config_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 6
);
    logic [ID_WIDTH-1:0]     awid;
    logic [31:0]             awaddr;
    logic [7:0]              awlen;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [31:0]             araddr;
    logic [7:0]              arlen;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/memoredf_config_slave_regfile.sv
// Byte-strobed configuration register array with one write port, a flat
// output bus and, only with MEMOREDF_CFG_READBACK_EN, one combinational read port.
module memoredf_cfg_regfile
    import memoredf_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]    wr_index,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_strb,
`ifdef MEMOREDF_CFG_READBACK_EN
    input  logic [$clog2(NUM_REGS)-1:0]    rd_index,
    output logic [DATA_WIDTH-1:0]          rd_data,
`endif
    output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // NOTE: this is a small flop array rather than a RAM macro, so resetting
    // every entry is cheap and gives software a known configuration.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: DATA_WIDTH'(REG_RESET_VALUE)};
        end else if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wr_strb[b]) regs[wr_index][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) cfg_regs[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

`ifdef MEMOREDF_CFG_READBACK_EN
    assign rd_data = regs[rd_index];
`endif

endmodule

// File: rtl/memoredf_config_slave.sv
// AXI4 slave exposing NUM_REGS configuration registers with concurrent
// write and read FSMs. Define MEMOREDF_CFG_READBACK_EN to return register data on reads.
module memoredf_config_slave
    import memoredf_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 6,
    parameter int NUM_REGS   = 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    memoredf_config_slave_if.slave         s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs,
    output logic                           cfg_wr_pulse
);

    localparam int         IDX_W     = $clog2(NUM_REGS);
    localparam reg_index_t REG_LIMIT = reg_index_t'(NUM_REGS);

    // ---------------- write channel ----------------
    wr_state_e           w_state, w_next;
    reg_index_t          w_idx;
    axi_burst_e          w_burst;
    logic [ID_WIDTH-1:0] w_id;
    logic                w_err, w_commit, wr_pulse_q;
    logic                awready, wready, bvalid;
    logic                aw_fire, w_fire, w_beat_ok, wr_en;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (s_axi.awvalid)                 w_next = W_DATA;
            W_DATA:  if (s_axi.wvalid && s_axi.wlast)   w_next = W_RESP;
            W_RESP:  if (s_axi.bready)                  w_next = W_IDLE;
            default:                                    w_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE:  awready = 1'b1;
            W_DATA:  wready  = 1'b1;
            W_RESP:  bvalid  = 1'b1;
            default: ;
        endcase
    end

    assign aw_fire   = s_axi.awvalid && awready;
    assign w_fire    = s_axi.wvalid && wready;
    assign w_beat_ok = (w_burst != BURST_WRAP) && (w_idx < REG_LIMIT);
    assign wr_en     = w_fire && w_beat_ok;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_id       <= '0;
            w_idx      <= '0;
            w_burst    <= BURST_FIXED;
            w_err      <= 1'b0;
            w_commit   <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            wr_pulse_q <= 1'b0;
            if (aw_fire) begin
                w_id     <= s_axi.awid;
                w_idx    <= base_index(s_axi.awaddr[ADDR_WINDOW_BITS-1:2]);
                w_burst  <= axi_burst_e'(s_axi.awburst);
                w_err    <= 1'b0;
                w_commit <= 1'b0;
            end
            if (w_fire) begin
                if (w_beat_ok) w_commit <= 1'b1;
                else           w_err    <= 1'b1;
                w_idx <= step_index(w_idx, w_burst);
                // The pulse lines up with the first bvalid cycle of the burst.
                if (s_axi.wlast) wr_pulse_q <= w_commit || w_beat_ok;
            end
        end
    end

    assign s_axi.awready = awready;
    assign s_axi.wready  = wready;
    assign s_axi.bvalid  = bvalid;
    assign s_axi.bid     = w_id;
    assign s_axi.bresp   = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
    assign cfg_wr_pulse  = wr_pulse_q;

    // ---------------- read channel ----------------
    rd_state_e             r_state, r_next;
    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_len, r_cnt;
    logic [DATA_WIDTH-1:0] rdata_q, beat_data;
    axi_resp_e             rresp_q, beat_resp;
    logic                  rlast_q;
    logic                  arready, rvalid, ar_fire, r_fire;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (s_axi.arvalid)              r_next = R_DATA;
            R_DATA:  if (s_axi.rready && rlast_q)    r_next = R_IDLE;
            default:                                 r_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE:  arready = 1'b1;
            R_DATA:  rvalid  = 1'b1;
            default: ;
        endcase
    end

    assign ar_fire = s_axi.arvalid && arready;
    assign r_fire  = rvalid && s_axi.rready;

`ifdef MEMOREDF_CFG_READBACK_EN
    reg_index_t            r_idx, sel_idx;
    axi_burst_e            r_burst, sel_burst;
    logic                  sel_ok;
    logic [DATA_WIDTH-1:0] rd_data;

    // Look up the beat about to be presented; capturing it on the same edge
    // that a write may hit returns the pre-write value.
    always_comb begin
        sel_idx   = ar_fire ? base_index(s_axi.araddr[ADDR_WINDOW_BITS-1:2])
                            : step_index(r_idx, r_burst);
        sel_burst = ar_fire ? axi_burst_e'(s_axi.arburst) : r_burst;
        sel_ok    = (sel_burst != BURST_WRAP) && (sel_idx < REG_LIMIT);
        beat_data = sel_ok ? rd_data : '0;
        beat_resp = sel_ok ? RESP_OKAY : RESP_SLVERR;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_idx   <= '0;
            r_burst <= BURST_FIXED;
        end else if (ar_fire) begin
            r_idx   <= sel_idx;
            r_burst <= sel_burst;
        end else if (r_fire && !rlast_q) begin
            r_idx   <= sel_idx;
        end
    end

    wire unused_addr_bits = ^{s_axi.awaddr[31:ADDR_WINDOW_BITS], s_axi.awaddr[1:0], s_axi.awlen,
                              s_axi.araddr[31:ADDR_WINDOW_BITS], s_axi.araddr[1:0]};
`else
    assign beat_data = '0;
    assign beat_resp = RESP_SLVERR;

    wire unused_addr_bits = ^{s_axi.awaddr[31:ADDR_WINDOW_BITS], s_axi.awaddr[1:0], s_axi.awlen,
                              s_axi.araddr, s_axi.arburst};
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end else if (ar_fire) begin
            r_id    <= s_axi.arid;
            r_len   <= s_axi.arlen;
            r_cnt   <= '0;
            rdata_q <= beat_data;
            rresp_q <= beat_resp;
            rlast_q <= (s_axi.arlen == 8'd0);
        end else if (r_fire) begin
            if (rlast_q) begin
                rlast_q <= 1'b0;
            end else begin
                r_cnt   <= r_cnt + 8'd1;
                rdata_q <= beat_data;
                rresp_q <= beat_resp;
                rlast_q <= (r_cnt + 8'd1 == r_len);
            end
        end
    end

    assign s_axi.arready = arready;
    assign s_axi.rvalid  = rvalid;
    assign s_axi.rid     = r_id;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;

    // ---------------- register storage ----------------
    memoredf_cfg_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk      (aclk),
        .rst_n    (aresetn),
        .wr_en    (wr_en),
        .wr_index (w_idx[IDX_W-1:0]),
        .wr_data  (s_axi.wdata),
        .wr_strb  (s_axi.wstrb),
`ifdef MEMOREDF_CFG_READBACK_EN
        .rd_index (sel_idx[IDX_W-1:0]),
        .rd_data  (rd_data),
`endif
        .cfg_regs (cfg_regs)
    );

endmodule

// File: tb/tb_memoredf_config_slave.sv
// Directed bench for memoredf_config_slave; read expectations follow
// whether MEMOREDF_CFG_READBACK_EN is defined.
module tb_memoredf_config_slave;

    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 6;
    localparam int NUM_REGS   = 8;
    localparam int TMO        = 64;

`ifdef MEMOREDF_CFG_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic                           aclk = 1'b0;
    logic                           aresetn = 1'b0;
    logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs;
    logic                           cfg_wr_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;
    int b_cnt = 0;

    logic [31:0] wbeat [0:7];
    logic [31:0] rd_beat_data [0:7];
    logic [1:0]  rd_beat_resp [0:7];
    logic        rd_beat_last [0:7];
    logic [5:0]  rd_id_seen;
    int          rd_beats;

    memoredf_config_slave_if #(.DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)) s_axi ();

    memoredf_config_slave #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axi        (s_axi.slave),
        .cfg_regs     (cfg_regs),
        .cfg_wr_pulse (cfg_wr_pulse)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) if (aresetn && cfg_wr_pulse) pulse_cnt++;
    always @(posedge aclk) if (aresetn && s_axi.bvalid && s_axi.bready) b_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_at(input int i);
        return cfg_regs[i*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, " awready"}, s_axi.awready, 1);
        check({pfx, " arready"}, s_axi.arready, 1);
        check({pfx, " wready"},  s_axi.wready, 0);
        check({pfx, " bvalid"},  s_axi.bvalid, 0);
        check({pfx, " rvalid"},  s_axi.rvalid, 0);
        check({pfx, " rlast"},   s_axi.rlast, 0);
        check({pfx, " bresp"},   s_axi.bresp, 0);
        check({pfx, " rresp"},   s_axi.rresp, 0);
        check({pfx, " cfg_regs"}, |cfg_regs, 0);
        check({pfx, " pulse"},   cfg_wr_pulse, 0);
    endtask

    task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [5:0] id);
        int n = 0;
        s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = len;
        s_axi.awburst = burst; s_axi.awvalid = 1'b1;
        while (!s_axi.awready && n < TMO) begin @(posedge aclk); #1; n++; end
        if (n == TMO) check("aw timeout", 1, 0);
        @(posedge aclk); #1;
        s_axi.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        s_axi.wdata = data; s_axi.wstrb = strb; s_axi.wlast = last; s_axi.wvalid = 1'b1;
        while (!s_axi.wready && n < TMO) begin @(posedge aclk); #1; n++; end
        if (n == TMO) check("w timeout", 1, 0);
        check("bvalid before wlast", s_axi.bvalid, 0);
        @(posedge aclk); #1;
        s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [3:0] strb,
                               input logic [5:0] id, output logic [1:0] resp,
                               output logic [5:0] bid_seen);
        int n = 0;
        aw_phase(addr, len, burst, id);
        for (int i = 0; i <= int'(len); i++) w_beat(wbeat[i], strb, i == int'(len));
        s_axi.bready = 1'b1;
        while (!s_axi.bvalid && n < TMO) begin @(posedge aclk); #1; n++; end
        if (n == TMO) check("b timeout", 1, 0);
        resp = s_axi.bresp;
        bid_seen = s_axi.bid;
        @(posedge aclk); #1;
        s_axi.bready = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [5:0] id, input bit toggle);
        int n = 0;
        bit stalled = 1'b0;
        logic [31:0] held_data = '0;
        logic held_last = 1'b0;
        s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = len;
        s_axi.arburst = burst; s_axi.arvalid = 1'b1;
        while (!s_axi.arready && n < TMO) begin @(posedge aclk); #1; n++; end
        if (n == TMO) check("ar timeout", 1, 0);
        @(posedge aclk); #1;
        s_axi.arvalid = 1'b0;
        rd_beats = 0;
        n = 0;
        s_axi.rready = !toggle;
        while (rd_beats <= int'(len) && rd_beats < 8 && n < TMO) begin
            if (stalled) begin
                check("rdata held", s_axi.rdata, held_data);
                check("rlast held", s_axi.rlast, held_last);
            end
            stalled   = s_axi.rvalid && !s_axi.rready;
            held_data = s_axi.rdata;
            held_last = s_axi.rlast;
            if (s_axi.rvalid && s_axi.rready) begin
                rd_beat_data[rd_beats] = s_axi.rdata;
                rd_beat_resp[rd_beats] = s_axi.rresp;
                rd_beat_last[rd_beats] = s_axi.rlast;
                rd_id_seen = s_axi.rid;
                rd_beats++;
            end
            @(posedge aclk); #1;
            n++;
            if (toggle) s_axi.rready = !s_axi.rready;
        end
        s_axi.rready = 1'b0;
        check("read beat count", rd_beats, int'(len) + 1);
        @(posedge aclk); #1;
        check("rvalid after burst", s_axi.rvalid, 0);
    endtask

    initial begin : stim
        logic [1:0]  resp;
        logic [5:0]  bid_seen;
        logic [NUM_REGS*DATA_WIDTH-1:0] snap;
        int p0, b0;

        s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awburst = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b0;
        s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arburst = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("reset");
        aresetn = 1'b1;

        // Single write to register 0.
        p0 = pulse_cnt;
        wbeat[0] = 32'h89AB_CDEF;
        write_burst(32'hC000_0000, 8'd0, 2'b01, 4'hF, 6'd3, resp, bid_seen);
        check("single bresp", resp, 2'b00);
        check("single bid", bid_seen, 6'd3);
        check("single reg0", reg_at(0), 32'h89AB_CDEF);
        check("single pulse count", pulse_cnt - p0, 1);

        // INCR burst over registers 1..4.
        b0 = b_cnt;
        wbeat[0] = 32'd1; wbeat[1] = 32'd2; wbeat[2] = 32'd3; wbeat[3] = 32'd4;
        write_burst(32'hC000_0004, 8'd3, 2'b01, 4'hF, 6'd21, resp, bid_seen);
        check("incr bresp", resp, 2'b00);
        check("incr bid", bid_seen, 6'd21);
        check("incr b count", b_cnt - b0, 1);
        check("incr reg1", reg_at(1), 32'd1);
        check("incr reg2", reg_at(2), 32'd2);
        check("incr reg3", reg_at(3), 32'd3);
        check("incr reg4", reg_at(4), 32'd4);
        check("incr reg5 untouched", reg_at(5), 32'd0);

        // Partial strobe on register 0.
        wbeat[0] = 32'hFFFF_FFFF;
        write_burst(32'hC000_0000, 8'd0, 2'b01, 4'h3, 6'd1, resp, bid_seen);
        check("strb bresp", resp, 2'b00);
        check("strb reg0", reg_at(0), 32'h89AB_FFFF);

        // INCR read with rready toggling every cycle.
        read_burst(32'hC000_0000, 8'd1, 2'b01, 6'd9, 1'b1);
        check("read beat0 data", rd_beat_data[0], READBACK ? 32'h89AB_FFFF : 32'h0);
        check("read beat0 resp", rd_beat_resp[0], READBACK ? 2'b00 : 2'b10);
        check("read beat0 rlast", rd_beat_last[0], 0);
        check("read beat1 data", rd_beat_data[1], READBACK ? 32'h1 : 32'h0);
        check("read beat1 resp", rd_beat_resp[1], READBACK ? 2'b00 : 2'b10);
        check("read beat1 rlast", rd_beat_last[1], 1);
        check("read rid", rd_id_seen, 6'd9);

        // FIXED burst keeps hitting register 2; register 3 is left alone.
        wbeat[0] = 32'h11; wbeat[1] = 32'h22;
        write_burst(32'hC000_0008, 8'd1, 2'b00, 4'hF, 6'd5, resp, bid_seen);
        check("fixed bresp", resp, 2'b00);
        check("fixed reg2", reg_at(2), 32'h22);
        check("fixed reg3", reg_at(3), 32'd3);

        // Out-of-range index 8: dropped, SLVERR, no pulse.
        p0 = pulse_cnt;
        snap = cfg_regs;
        wbeat[0] = 32'hDEAD_BEEF;
        write_burst(32'hC000_0020, 8'd0, 2'b01, 4'hF, 6'd2, resp, bid_seen);
        check("oor bresp", resp, 2'b10);
        check("oor regs unchanged", cfg_regs == snap, 1);
        check("oor pulse count", pulse_cnt - p0, 0);
        read_burst(32'hC000_0020, 8'd0, 2'b01, 6'd4, 1'b0);
        check("oor read data", rd_beat_data[0], 32'h0);
        check("oor read resp", rd_beat_resp[0], 2'b10);
        check("oor read rlast", rd_beat_last[0], 1);

        // WRAP burst writes nothing.
        snap = cfg_regs;
        wbeat[0] = 32'hAAAA_AAAA; wbeat[1] = 32'hBBBB_BBBB;
        write_burst(32'hC000_0004, 8'd1, 2'b10, 4'hF, 6'd6, resp, bid_seen);
        check("wrap bresp", resp, 2'b10);
        check("wrap regs unchanged", cfg_regs == snap, 1);

        // Reset during beat 2 of a len-3 write.
        aw_phase(32'hC000_0010, 8'd3, 2'b01, 6'd8);
        w_beat(32'hA0, 4'hF, 1'b0);
        check("pre-reset reg4", reg_at(4), 32'hA0);
        s_axi.wdata = 32'hA1; s_axi.wstrb = 4'hF; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b1;
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midburst reset");
        s_axi.wvalid = 1'b0;
        @(posedge aclk); #1;
        check_reset_outputs("held reset");
        aresetn = 1'b1;

        p0 = pulse_cnt;
        wbeat[0] = 32'h55;
        write_burst(32'hC000_0008, 8'd0, 2'b01, 4'hF, 6'd7, resp, bid_seen);
        check("post-reset bresp", resp, 2'b00);
        check("post-reset bid", bid_seen, 6'd7);
        check("post-reset reg2", reg_at(2), 32'h55);
        check("post-reset reg4", reg_at(4), 32'h0);
        check("post-reset pulse", pulse_cnt - p0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
